uart_tx_ctrl: RTL

Transmit-side controller for the UART. It accepts a byte from the host via a LOAD/TXRDY handshake and builds an 11-bit frame: idle bit, start bit, data[6:0], then the two upper bits from decode_shr (bit 8 or parity, and stop or parity). It times each bit with a programmable bit-time counter and shifts the frame out LSB-first on TX. It sits between the host register interface and the serial pin, and owns the only instance of decode_shr on the TX path.

---
 rtl/uart_pkg.sv | 14 +
 rtl/bit_time_ctr.sv | 26 ++
 rtl/decode_shr.sv | 29 ++
 rtl/uart_tx_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX controller state encoding, frame length, idle line pattern.
// Imported by the TX controller and its sub-modules.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOADSR = 2'b01,
    SHIFT  = 2'b10
  } tx_state_t;

  localparam int          NBITS   = 11;
  localparam logic [10:0] SR_IDLE = 11'h7FF;

endpackage

// File: rtl/bit_time_ctr.sv
// Bit-time counter with unit-time (btu) equality compare; wraps to 0 on btu while enabled.
// btu is combinational from the count and bit_time; clear takes priority over enable.
module bit_time_ctr #(
  parameter int BT_W = 19
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [BT_W-1:0] bit_time,
  output logic            btu
);

  logic [BT_W-1:0] cnt;

  assign btu = (cnt == bit_time);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= btu ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/decode_shr.sv
// Picks the two frame bits above data[6:0]: {stop-or-parity, bit7-or-parity-or-stop}.
// Pure combinational, no handshake.
module decode_shr (
  input  logic [7:0] data_in,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  output logic [1:0] data_out
);

  logic par7;
  logic par8;

  // Odd parity inverts the XOR reduction so the total count of ones comes out odd.
  assign par7 = ohel ? ~^data_in[6:0] : ^data_in[6:0];
  assign par8 = ohel ? ~^data_in      : ^data_in;

  always_comb begin
    data_out = 2'b11;
    case ({eight, pen})
      2'b00: data_out = 2'b11;
      2'b01: data_out = {1'b1, par7};
      2'b10: data_out = {1'b1, data_in[7]};
      2'b11: data_out = {par8, data_in[7]};
      default: data_out = 2'b11;
    endcase
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: captures a byte on LOAD/TXRDY, serialises an 11-bit frame LSB-first.
// Frame occupies 1 LOADSR cycle plus 11*(BIT_TIME+1) clocks; LOAD is ignored while TXRDY=0.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int BT_W = 19
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            LOAD,
  input  logic [7:0]      LOAD_DATA,
  input  logic            EIGHT,
  input  logic            PEN,
  input  logic            OHEL,
  input  logic [BT_W-1:0] BIT_TIME,
  output logic            TX,
  output logic            TXRDY,
  output logic            TX_DONE
);

  tx_state_t   state;
  tx_state_t   state_nxt;
  logic [10:0] sr;
  logic [3:0]  bit_cnt;
  logic [7:0]  hold_dat;
  logic        hold_eight;
  logic        hold_pen;
  logic        hold_ohel;
  logic [1:0]  dec_out;
  logic        btu;
  logic        capture;
  logic        load_sr;
  logic        shift_en;
  logic        ctr_en;
  logic        last_bit;
  logic        done_nxt;

  decode_shr u_decode_shr (
    .data_in  (hold_dat),
    .eight    (hold_eight),
    .pen      (hold_pen),
    .ohel     (hold_ohel),
    .data_out (dec_out)
  );

  bit_time_ctr #(.BT_W(BT_W)) u_bit_time_ctr (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .clr      (load_sr),
    .en       (ctr_en),
    .bit_time (BIT_TIME),
    .btu      (btu)
  );

  assign TX       = sr[0];
  assign TXRDY    = (state == IDLE);
  assign last_bit = (bit_cnt == 4'(NBITS - 1));

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    load_sr   = 1'b0;
    shift_en  = 1'b0;
    ctr_en    = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (LOAD) begin
          capture   = 1'b1;
          state_nxt = LOADSR;
        end
      end
      LOADSR: begin
        load_sr   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        ctr_en   = 1'b1;
        shift_en = btu;
        if (btu && last_bit) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= IDLE;
      sr         <= SR_IDLE;
      bit_cnt    <= '0;
      hold_dat   <= '0;
      hold_eight <= 1'b0;
      hold_pen   <= 1'b0;
      hold_ohel  <= 1'b0;
      TX_DONE    <= 1'b0;
    end else begin
      state   <= state_nxt;
      TX_DONE <= done_nxt;
      if (capture) begin
        hold_dat   <= LOAD_DATA;
        hold_eight <= EIGHT;
        hold_pen   <= PEN;
        hold_ohel  <= OHEL;
      end
      // Frame LSB first: idle 1, start 0, d[6:0], then the two decoded upper bits.
      if (load_sr) begin
        sr      <= {dec_out[1], dec_out[0], hold_dat[6:0], 1'b0, 1'b1};
        bit_cnt <= '0;
      end else if (shift_en) begin
        sr      <= {1'b1, sr[10:1]};
        bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
      end
    end
  end

endmodule
